// File: rtl/req_gnt_arbiter.sv
// Request/grant arbiter: a cycle-start strobe latches one winner, which is granted for GNT_LEN cycles.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise fixed priority (lowest index wins).
module req_gnt_arbiter #(
  parameter int N       = 4,
  parameter int GNT_LEN = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cstart,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt,
  output logic         busy,
  output logic [7:0]   drop_cnt,
  output logic         err
);

  localparam int IDXW = $clog2(N);
  localparam int CNTW = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    GNT  = 2'd2
  } state_t;

  state_t          state;
  logic [IDXW-1:0] winner;
  logic [IDXW-1:0] pick;
  logic [CNTW-1:0] hold_cnt;
  logic            found;
  logic            any_req;

  assign any_req = |req;

`ifdef ARB_ROUND_ROBIN_EN
  logic [IDXW-1:0] ptr;
  int unsigned     scan;

  // Scan starting at the pointer; the conditional subtract implements the modulo-N wrap.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    scan  = 0;
    for (int unsigned i = 0; i < N; i++) begin
      scan = 32'(ptr) + i;
      if (scan >= N) scan = scan - N;
      if (!found && req[scan[IDXW-1:0]]) begin
        found = 1'b1;
        pick  = scan[IDXW-1:0];
      end
    end
  end
`else
  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!found && req[IDXW'(i)]) begin
        found = 1'b1;
        pick  = IDXW'(i);
      end
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      gnt      <= '0;
      busy     <= 1'b0;
      drop_cnt <= '0;
      err      <= 1'b0;
      winner   <= '0;
      hold_cnt <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      ptr      <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (cstart) begin
            if (any_req && found) begin
              winner <= pick;
              state  <= ARB;
              busy   <= 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
              ptr    <= (pick == IDXW'(N-1)) ? '0 : pick + 1'b1;
`endif
            end else begin
              err <= 1'b1;
            end
          end
        end
        ARB: begin
          gnt      <= {{(N-1){1'b0}}, 1'b1} << winner;
          hold_cnt <= CNTW'(GNT_LEN - 1);
          state    <= GNT;
          if (cstart && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
        end
        GNT: begin
          // A start on the final grant edge is still a busy-period start and is dropped.
          if (cstart && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
          if (hold_cnt == '0) begin
            state <= IDLE;
            gnt   <= '0;
            busy  <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          gnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_req_gnt_arbiter.sv
// Randomized and directed bench for req_gnt_arbiter; two instances (GNT_LEN 1 and 3) share stimulus.
module tb_req_gnt_arbiter;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cstart;
  logic [N-1:0] req;
  logic [N-1:0] gnt0, gnt1;
  logic         busy0, busy1;
  logic [7:0]   drop0, drop1;
  logic         err0, err1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  req_gnt_arbiter #(.N(N), .GNT_LEN(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .cstart(cstart), .req(req),
    .gnt(gnt0), .busy(busy0), .drop_cnt(drop0), .err(err0)
  );

  req_gnt_arbiter #(.N(N), .GNT_LEN(3)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .cstart(cstart), .req(req),
    .gnt(gnt1), .busy(busy1), .drop_cnt(drop1), .err(err1)
  );

  // An accepted start (idle, strobe, some request) must produce a one-hot grant two edges later.
  a_lat0: assert property (@(posedge clk) disable iff (!rst_n)
    (cstart && (|req) && !busy0) |-> ##2 $onehot(gnt0))
    else begin failures++; $display("FAIL a_lat0 grant missing two edges after start"); end
  a_lat1: assert property (@(posedge clk) disable iff (!rst_n)
    (cstart && (|req) && !busy1) |-> ##2 $onehot(gnt1))
    else begin failures++; $display("FAIL a_lat1 grant missing two edges after start"); end
  a_oh0: assert property (@(posedge clk) $onehot0(gnt0))
    else begin failures++; $display("FAIL a_oh0 gnt0=%b not one-hot", gnt0); end
  a_oh1: assert property (@(posedge clk) $onehot0(gnt1))
    else begin failures++; $display("FAIL a_oh1 gnt1=%b not one-hot", gnt1); end

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: per instance, a transaction is an age counter since the accept edge.
  int unsigned glen [2] = '{1, 3};
  bit          m_act[2];
  int unsigned m_age[2];
  int unsigned m_win[2];
  int unsigned m_ptr[2];
  int unsigned m_drop[2];
  bit          m_err[2];

  function automatic int unsigned pick_winner(input int unsigned ptr, input logic [N-1:0] r);
    for (int k = 0; k < N; k++) begin
      int unsigned idx;
      idx = (ptr + k) % N;
      if (r[idx]) return idx;
    end
    return 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_act[i] = 0; m_age[i] = 0; m_win[i] = 0;
      m_ptr[i] = 0; m_drop[i] = 0; m_err[i] = 0;
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      if (!m_act[i]) begin
        if (cstart) begin
          if (req != 0) begin
            m_win[i] = pick_winner(m_ptr[i], req);
`ifdef ARB_ROUND_ROBIN_EN
            m_ptr[i] = (m_win[i] + 1) % N;
`endif
            m_act[i] = 1;
            m_age[i] = 0;
          end else begin
            m_err[i] = 1;
          end
        end
      end else begin
        if (cstart && m_drop[i] < 255) m_drop[i]++;
        m_age[i]++;
        if (m_age[i] > glen[i]) m_act[i] = 0;
      end
    end
  endtask

  function automatic int unsigned exp_gnt(input int i);
    if (m_act[i] && m_age[i] >= 1) return 1 << m_win[i];
    return 0;
  endfunction

  task automatic check_outputs();
    check("gnt0",  gnt0,  exp_gnt(0));
    check("busy0", busy0, m_act[0]);
    check("drop0", drop0, m_drop[0]);
    check("err0",  err0,  m_err[0]);
    check("gnt1",  gnt1,  exp_gnt(1));
    check("busy1", busy1, m_act[1]);
    check("drop1", drop1, m_drop[1]);
    check("err1",  err1,  m_err[1]);
  endtask

  // Called at a negedge: drive, take one posedge, update the model, compare at the next negedge.
  task automatic cycle(input logic cs, input logic [N-1:0] r);
    cstart = cs;
    req    = r;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic drain(input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, '0);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_gnt0", gnt0, 0);
    check("rst_busy0", busy0, 0);
    check("rst_drop0", drop0, 0);
    check("rst_err0", err0, 0);
    check("rst_gnt1", gnt1, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [N-1:0] rr_exp [3];
  logic [N-1:0] seen;

  initial begin
    rst_n  = 1'b0;
    cstart = 1'b0;
    req    = '0;
    @(negedge clk);
    apply_reset();

    // Single start, accepted on the first edge after release.
    cycle(1'b1, 4'b0001);
    check("single_busy", busy0, 1);
    check("single_gnt_arb", gnt0, 0);
    cycle(1'b0, 4'b0000);
    check("single_gnt", gnt0, 4'b0001);
    cycle(1'b0, 4'b0000);
    check("single_gnt_clr", gnt0, 0);
    check("single_busy_clr", busy0, 0);
    drain(4);

    // Contention: three accepted starts with req=1010.
`ifdef ARB_ROUND_ROBIN_EN
    rr_exp = '{4'b0010, 4'b1000, 4'b0010};
`else
    rr_exp = '{4'b0010, 4'b0010, 4'b0010};
`endif
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, 4'b1010);
      cycle(1'b0, 4'b0000);
      seen = gnt0;
      check($sformatf("contend%0d", k), seen, rr_exp[k]);
      drain(4);
    end

    // Busy drops: start, then starts on the next two edges.
    cycle(1'b1, 4'b0001);
    cycle(1'b1, 4'b0011);
    cycle(1'b1, 4'b0100);
    check("drop_two", drop0, 2);
    drain(4);
    for (int k = 0; k < 450; k++) cycle(1'b1, 4'b0110);
    check("drop_sat", drop0, 255);
    drain(4);

    // Empty start sets a sticky error.
    cycle(1'b1, 4'b0000);
    check("empty_err", err0, 1);
    check("empty_busy", busy0, 0);
    cycle(1'b0, 4'b0000);
    check("empty_gnt", gnt0, 0);
    cycle(1'b1, 4'b1000);
    drain(4);
    check("err_sticky", err0, 1);

    // Reset shortly after an accepted start: no grant pulse leaks out.
    cycle(1'b1, 4'b0001);
    cstart = 1'b0;
    req    = '0;
    apply_reset();
    check("midrst_gnt", gnt0, 0);
    cycle(1'b1, 4'b0100);
    cycle(1'b0, 4'b0000);
    check("postrst_gnt", gnt0, 4'b0100);
    drain(4);

    // Randomized traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      logic         cs;
      logic [N-1:0] r;
      cs = ($urandom_range(0, 9) < 4);
      r  = N'($urandom);
      if ($urandom_range(0, 7) == 0) r = '0;
      cycle(cs, r);
    end
    drain(6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
